// File: rtl/aes_dec_pkg.sv
// Shared types, constants and column helpers for the AES decryption datapath.
// Column c of a state occupies bits [127-32c -: 32], row 0 in the MSB byte.
package aes_dec_pkg;

  localparam logic [7:0] AES_GF_POLY = 8'h1b;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  function automatic word_t get_col(input state_t s, input logic [1:0] c);
    word_t w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (c == i[1:0]) w = s[127-32*i -: 32];
    end
    return w;
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] c, input word_t w);
    state_t r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (c == i[1:0]) r[127-32*i -: 32] = w;
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the MSB byte).
// Products by 9/b/d/e are built from the x2/x4/x8 xtime chain of each byte.
module inv_mix_col_word
  import aes_dec_pkg::*;
(
  input  word_t col,
  output word_t res
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign a[gi]  = col[31-8*gi -: 8];
      assign x2[gi] = xtime(a[gi]);
      assign x4[gi] = xtime(x2[gi]);
      assign x8[gi] = xtime(x4[gi]);
      assign m9[gi] = x8[gi] ^ a[gi];
      assign mb[gi] = x8[gi] ^ x2[gi] ^ a[gi];
      assign md[gi] = x8[gi] ^ x4[gi] ^ a[gi];
      assign me[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
    end

    // Row r uses coefficients e,b,d,9 starting at byte r and rotating.
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign res[31-8*gi -: 8] = me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4];
    end
  endgenerate

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequencer sharing one InvMixColumns column engine across the four columns
// of a state, with valid/ready on both sides and a per-state bypass.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
#(
  parameter int ENGINE_STAGES = 0,
  parameter int NUM_COLS      = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (NUM_COLS != 4) begin : g_bad_cols
      $error("inv_mix_columns_seq: NUM_COLS must be 4");
    end
    if (ENGINE_STAGES != 0 && ENGINE_STAGES != 1) begin : g_bad_stages
      $error("inv_mix_columns_seq: ENGINE_STAGES must be 0 or 1");
    end
  endgenerate

  localparam fsm_t RUN_EXIT = (ENGINE_STAGES == 1) ? ST_DRAIN : ST_DONE;

  fsm_t       state_reg, state_next;
  logic [1:0] col_cnt_reg, col_cnt_next;
  state_t     src_reg, res_reg;
  word_t      eng_in, eng_out, wr_word;
  logic       wr_en;
  logic [1:0] wr_col;
  logic       accept;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_state = res_reg;
  assign accept    = in_ready && in_valid && !flush;
  assign eng_in    = get_col(src_reg, col_cnt_reg);

  inv_mix_col_word u_engine (
    .col (eng_in),
    .res (eng_out)
  );

  // With a pipelined engine each result lands one cycle late, so the write
  // column trails col_cnt and DRAIN retires the last column.
  generate
    if (ENGINE_STAGES == 1) begin : g_pipe
      word_t pipe_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pipe_reg <= '0;
        else if (state_reg == ST_RUN) pipe_reg <= eng_out;
      end
      assign wr_en   = (state_reg == ST_RUN && col_cnt_reg != 2'd0) || (state_reg == ST_DRAIN);
      assign wr_col  = (state_reg == ST_DRAIN) ? 2'd3 : col_cnt_reg - 2'd1;
      assign wr_word = pipe_reg;
    end else begin : g_comb
      assign wr_en   = (state_reg == ST_RUN);
      assign wr_col  = col_cnt_reg;
      assign wr_word = eng_out;
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    col_cnt_next = col_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        col_cnt_next = 2'd0;
        if (in_valid) state_next = in_bypass ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        col_cnt_next = col_cnt_reg + 2'd1;
        if (col_cnt_reg == 2'd3) state_next = RUN_EXIT;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next   = ST_IDLE;
      col_cnt_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      col_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      col_cnt_reg <= col_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= '0;
      res_reg <= '0;
    end else begin
      if (accept) src_reg <= in_state;
      if (accept && in_bypass) res_reg <= in_state;
      else if (wr_en)          res_reg <= set_col(res_reg, wr_col, wr_word);
    end
  end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Sequencer for the AES-256 decryption InvMixColumns step.
- Accepts a 128-bit round state over a valid/ready handshake and time-multiplexes one shared 32-bit InvMixColumns column engine over the four columns. Returns the transformed state over a second valid/ready handshake.
- Sits between InvSubBytes/AddRoundKey and the round register in the decryption round loop.
- A per-transaction bypass skips the transform for the final round.

Parameters:
- ENGINE_STAGES, 0, pipeline registers after the column engine; legal values 0 or 1. A value of 1 adds exactly one cycle of total latency.
- NUM_COLS, 4, columns per state; fixed at 4, any other value is a elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  state; column c = in_state[127-32c -: 32], row 0 in the MSB byte of each column.
- in_bypass  in  1  sampled with the state; 1 = pass through unchanged.
- flush  in  1  synchronous abort; discards any transaction in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  result, same column layout as in_state.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, col_cnt=0, all state/result registers=0, engine pipeline register=0.
  - in_ready=1, out_valid=0, out_state=0, busy=0.
- FSM states: IDLE, RUN, DRAIN (only when ENGINE_STAGES=1), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_state into src_reg and in_bypass into byp_reg.
  - If bypass: copy src to res_reg and go to DONE.
  - Otherwise: col_cnt=0, go to RUN.
- RUN:
  - Engine input = column col_cnt of src_reg.
  - ENGINE_STAGES=0: engine output is written to res_reg column col_cnt in the same cycle.
  - ENGINE_STAGES=1: the registered output is written to column col_cnt-1 on the following cycle.
  - col_cnt increments by 1 per cycle.
  - At col_cnt=3: go to DONE (stages=0) or DRAIN (stages=1).
  - col_cnt is 2 bits and wraps to 0 on leaving RUN.
- DRAIN: writes column 3 from the pipeline register, then goes to DONE.
- DONE:
  - out_valid=1; out_state=res_reg, held stable while out_ready=0.
  - On out_ready: go to IDLE. out_valid falls the next cycle.
- Latency: acceptance at cycle T.
  - Transform, stages=0: out_valid first high in cycle T+5.
  - Transform, stages=1: out_valid first high in cycle T+6.
  - Bypass: out_valid first high in cycle T+1.
- Throughput: in_ready is high only in IDLE. There is no overlap, so back-to-back transform blocks are accepted at most every 6 cycles (stages=0).
- Column engine: combinational GF(2^8) InvMixColumns with coefficients e,b,d,9 rotated per row. Each output byte is an XOR of four GF products; all arithmetic is modulo x^8+x^4+x^3+x+1.
- flush:
  - Has priority over every other transition, including acceptance in the same cycle.
  - Next state is IDLE, col_cnt=0, out_valid=0. res_reg is not required to clear.
  - A flush in IDLE is a no-op; an in_valid presented with it is not accepted.
- Async reset mid-transaction: the transaction is lost; outputs return to reset values immediately.
- in_valid while not in_ready: ignored. Upstream must hold it.

Decomposition:
- Package aes_dec_pkg:
  - AES_GF_POLY constant 8'h1b.
  - state_t typedef (128), word_t typedef (32).
  - FSM state enum.
  - Column-extract/insert helper functions.
- Sub-module: inv_mix_col_word
  - Pure combinational, 32-bit in, 32-bit out.
  - Implements xtime-based multiplication by 9/b/d/e.
  - Instantiated once and shared across columns.

Test Plan:
- Reset: rst_n low for 3 cycles, then high -> in_ready=1, out_valid=0, busy=0, out_state=0.
- Transform (stages=0), in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass=0 -> out_valid at T+5, out_state=db135345_f20a225c_01010101_d4d4d4d5.
- Bypass, in_state=00112233_44556677_8899aabb_ccddeeff, bypass=1 -> out_valid at T+1, out_state identical to in_state.
- Backpressure: out_ready held 0 for 10 cycles after the transform vector -> out_valid and out_state stable throughout, in_ready=0. Release -> IDLE one cycle later.
- Flush in the 2nd RUN cycle, then a new transform of c6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6 -> no out_valid for the flushed transaction. Result=c6c6c6c6 in all columns.
- Reset mid-RUN (rst_n pulsed low at T+2), then the ENGINE_STAGES=1 build with the first vector -> outputs clear immediately. A later transform yields the same result at T+6.
